// File: rtl/proc_pkg.sv
// Shared processor definitions: default datapath sizes and opcode encodings.
package proc_pkg;

  localparam int WORD_W   = 16;
  localparam int REG_AW   = 6;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_LD   = 4'd1,
    OP_ST   = 4'd2,
    OP_MOV  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_ADDF = 4'd9,
    OP_MULF = 4'd10
  } opcode_t;

endpackage

// File: rtl/pending_scoreboard.sv
// Pending-write scoreboard: tracks in-flight destinations, detects RAW/WAW
// hazards against decode, and keeps a registered count of pending registers.
module pending_scoreboard
  import proc_pkg::*;
#(
  parameter  int NREGS = NUM_REGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_a_addr,
  input  logic [AW-1:0] rd_b_addr,
  input  logic          iss_valid,
  input  logic          iss_use_a,
  input  logic          iss_use_b,
  input  logic          iss_dst_en,
  input  logic [AW-1:0] iss_dst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic          flush,
  output logic          iss_ready,
  output logic          wb_hit_pending,
  output logic [AW:0]   pending_cnt
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             hz_a, hz_b, hz_d;

  // Hazard detection; a same-cycle writeback to the register resolves it.
  always_comb begin
    hz_a           = iss_use_a  && pending_q[rd_a_addr] && !(wb_valid && wb_addr == rd_a_addr);
    hz_b           = iss_use_b  && pending_q[rd_b_addr] && !(wb_valid && wb_addr == rd_b_addr);
    hz_d           = iss_dst_en && pending_q[iss_dst]   && !(wb_valid && wb_addr == iss_dst);
    iss_ready      = !(hz_a || hz_b || hz_d) && !flush;
    wb_hit_pending = pending_q[wb_addr];
  end

  // Next pending vector: flush clears all, otherwise an issue set overrides a writeback clear.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wb_valid) pending_d[wb_addr] = 1'b0;
      if (iss_valid && iss_ready && iss_dst_en) pending_d[iss_dst] = 1'b1;
    end
    cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, pending_d[i]};
    end
  end

  // Scoreboard state and its popcount update together so the count never lags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational write-through read ports, one
// writeback port, and a pending-write scoreboard for decode hazard stalls.
module regfile_scoreboard
  import proc_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int NREGS = NUM_REGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_a_addr,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [WIDTH-1:0] rd_b_data,
  input  logic             iss_valid,
  input  logic             iss_use_a,
  input  logic             iss_use_b,
  input  logic             iss_dst_en,
  input  logic [AW-1:0]    iss_dst,
  output logic             iss_ready,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic [AW:0]      pending_cnt,
  output logic             wb_err
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wb_err_q, wb_err_d;
  logic             wb_hit_pending;

  pending_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_a_addr      (rd_a_addr),
    .rd_b_addr      (rd_b_addr),
    .iss_valid      (iss_valid),
    .iss_use_a      (iss_use_a),
    .iss_use_b      (iss_use_b),
    .iss_dst_en     (iss_dst_en),
    .iss_dst        (iss_dst),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .flush          (flush),
    .iss_ready      (iss_ready),
    .wb_hit_pending (wb_hit_pending),
    .pending_cnt    (pending_cnt)
  );

  // Read ports bypass the writeback value so a consumer sees it in the same cycle.
  always_comb begin
    rd_a_data = (wb_valid && wb_addr == rd_a_addr) ? wb_data : regs_q[rd_a_addr];
    rd_b_data = (wb_valid && wb_addr == rd_b_addr) ? wb_data : regs_q[rd_b_addr];
  end

  // Writeback into the array; writing a register nobody was waiting on is sticky-flagged.
  always_comb begin
    regs_d   = regs_q;
    wb_err_d = wb_err_q;
    if (wb_valid) begin
      regs_d[wb_addr] = wb_data;
      if (!wb_hit_pending) wb_err_d = 1'b1;
    end
  end

  // Architectural register and error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '{default: '0};
      wb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance: WIDTH=16, NREGS=64
  logic [5:0]  rd_a_addr, rd_b_addr, iss_dst, wb_addr;
  logic [15:0] rd_a_data, rd_b_data, wb_data;
  logic        iss_valid, iss_use_a, iss_use_b, iss_dst_en, iss_ready;
  logic        wb_valid, flush, wb_err;
  logic [6:0]  pending_cnt;

  regfile_scoreboard #(.WIDTH(16), .NREGS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .iss_valid(iss_valid), .iss_use_a(iss_use_a), .iss_use_b(iss_use_b),
    .iss_dst_en(iss_dst_en), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  // Small instance: WIDTH=32, NREGS=8
  logic [2:0]  s_rd_a_addr, s_rd_b_addr, s_iss_dst, s_wb_addr;
  logic [31:0] s_rd_a_data, s_rd_b_data, s_wb_data;
  logic        s_iss_valid, s_iss_use_a, s_iss_use_b, s_iss_dst_en, s_iss_ready;
  logic        s_wb_valid, s_flush, s_wb_err;
  logic [3:0]  s_pending_cnt;

  regfile_scoreboard #(.WIDTH(32), .NREGS(8)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .rd_a_addr(s_rd_a_addr), .rd_a_data(s_rd_a_data),
    .rd_b_addr(s_rd_b_addr), .rd_b_data(s_rd_b_data),
    .iss_valid(s_iss_valid), .iss_use_a(s_iss_use_a), .iss_use_b(s_iss_use_b),
    .iss_dst_en(s_iss_dst_en), .iss_dst(s_iss_dst), .iss_ready(s_iss_ready),
    .wb_valid(s_wb_valid), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
    .flush(s_flush), .pending_cnt(s_pending_cnt), .wb_err(s_wb_err)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Behavioural model of the main instance
  logic [15:0] m_regs [64];
  bit          m_pend [64];
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [5:0] a);
    if (wb_valid && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit waits_on(input bit used, input logic [5:0] r);
    return used && m_pend[r] && !(wb_valid && wb_addr == r);
  endfunction

  function automatic bit exp_ready();
    if (flush) return 1'b0;
    if (waits_on(iss_use_a, rd_a_addr)) return 1'b0;
    if (waits_on(iss_use_b, rd_b_addr)) return 1'b0;
    if (waits_on(iss_dst_en, iss_dst)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < 64; i++) c += m_pend[i];
    return c;
  endfunction

  // Compare on the falling edge, then advance the model at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_on) begin
        chk("rd_a_data",   32'(rd_a_data),   32'(exp_rd(rd_a_addr)));
        chk("rd_b_data",   32'(rd_b_data),   32'(exp_rd(rd_b_addr)));
        chk("iss_ready",   32'(iss_ready),   32'(exp_ready()));
        chk("pending_cnt", 32'(pending_cnt), 32'(exp_cnt()));
        chk("wb_err",      32'(wb_err),      32'(m_err));
      end
      @(posedge clk);
      if (rst_n) begin
        bit rdy;
        rdy = exp_ready();
        if (wb_valid) begin
          if (!m_pend[wb_addr]) m_err = 1'b1;
          m_regs[wb_addr] = wb_data;
          m_pend[wb_addr] = 1'b0;
        end
        if (flush) begin
          for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
        end else if (iss_valid && rdy && iss_dst_en) begin
          m_pend[iss_dst] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_use_a = 0; iss_use_b = 0; iss_dst_en = 0; iss_dst = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0; flush = 0;
  endtask

  task automatic s_idle();
    s_rd_a_addr = '0; s_rd_b_addr = '0;
    s_iss_valid = 0; s_iss_use_a = 0; s_iss_use_b = 0; s_iss_dst_en = 0; s_iss_dst = '0;
    s_wb_valid = 0; s_wb_addr = '0; s_wb_data = '0; s_flush = 0;
  endtask

  task automatic issue(input logic [5:0] d);
    idle();
    iss_valid = 1; iss_dst_en = 1; iss_dst = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0;
    idle();
    s_idle();
    model_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Reset state
    rd_a_addr = 6'd5;
    @(negedge clk);
    chk("rst rd_a_data", 32'(rd_a_data), 32'h0000);
    chk("rst pending_cnt", 32'(pending_cnt), 0);
    chk("rst iss_ready", 32'(iss_ready), 1);
    chk("rst wb_err", 32'(wb_err), 0);
    tick();

    // RAW on R3
    issue(6'd3);
    tick();
    idle(); iss_valid = 1; iss_use_a = 1; rd_a_addr = 6'd3;
    @(negedge clk);
    chk("raw stall", 32'(iss_ready), 0);
    tick();
    tick();
    wb_valid = 1; wb_addr = 6'd3; wb_data = 16'h1234;
    @(negedge clk);
    chk("raw unstall", 32'(iss_ready), 1);
    chk("raw bypass", 32'(rd_a_data), 32'h1234);
    tick();
    idle(); rd_b_addr = 6'd3;
    @(negedge clk);
    chk("raw cnt", 32'(pending_cnt), 0);
    chk("raw regs", 32'(rd_b_data), 32'h1234);
    tick();

    // WAW on R7, then writeback coincident with the second issue
    issue(6'd7);
    tick();
    issue(6'd7);
    @(negedge clk);
    chk("waw stall", 32'(iss_ready), 0);
    tick();
    wb_valid = 1; wb_addr = 6'd7; wb_data = 16'h00FF;
    @(negedge clk);
    chk("waw unstall", 32'(iss_ready), 1);
    tick();
    idle(); rd_a_addr = 6'd7;
    @(negedge clk);
    chk("waw cnt", 32'(pending_cnt), 1);
    chk("waw data", 32'(rd_a_data), 32'h00FF);
    tick();
    wb_valid = 1; wb_addr = 6'd7; wb_data = 16'h0001;
    tick();

    // Flush with coincident writeback
    issue(6'd1); tick();
    issue(6'd2); tick();
    issue(6'd4); tick();
    idle();
    @(negedge clk);
    chk("flush pre cnt", 32'(pending_cnt), 3);
    tick();
    issue(6'd5);
    flush = 1; wb_valid = 1; wb_addr = 6'd2; wb_data = 16'h0042;
    @(negedge clk);
    chk("flush blocks issue", 32'(iss_ready), 0);
    tick();
    idle(); rd_a_addr = 6'd2;
    @(negedge clk);
    chk("flush cnt", 32'(pending_cnt), 0);
    chk("flush wb data", 32'(rd_a_data), 32'h0042);
    chk("flush wb_err", 32'(wb_err), 0);
    tick();

    // Writeback to a non-pending register
    wb_valid = 1; wb_addr = 6'd9; wb_data = 16'hBEEF;
    tick();
    idle(); rd_a_addr = 6'd9;
    @(negedge clk);
    chk("err data", 32'(rd_a_data), 32'hBEEF);
    chk("err set", 32'(wb_err), 1);
    tick();

    // Randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 800) begin
        idle();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async rst cnt", 32'(pending_cnt), 0);
        chk("async rst err", 32'(wb_err), 0);
        chk("async rst ready", 32'(iss_ready), 1);
        chk("async rst rd_a", 32'(rd_a_data), 32'h0000);
        tick();
        rst_n = 1'b1;
      end
      idle();
      rd_a_addr  = 6'($urandom_range(0, 7));
      rd_b_addr  = 6'($urandom_range(0, 7));
      iss_valid  = ($urandom_range(0, 9) < 7);
      iss_use_a  = $urandom_range(0, 1);
      iss_use_b  = $urandom_range(0, 1);
      iss_dst_en = ($urandom_range(0, 3) != 0);
      iss_dst    = 6'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) < 4) begin
        int cand [$];
        for (int r = 0; r < 64; r++) if (m_pend[r]) cand.push_back(r);
        wb_valid = 1;
        wb_data  = 16'($urandom);
        if (cand.size() > 0 && $urandom_range(0, 19) != 0)
          wb_addr = 6'(cand[$urandom_range(0, cand.size() - 1)]);
        else
          wb_addr = 6'($urandom_range(0, 15));
      end
      tick();
    end
    idle();
    tick();

    // Small instance: RAW with a 32-bit word on R7
    chk_on = 1'b0;
    s_idle();
    s_iss_valid = 1; s_iss_dst_en = 1; s_iss_dst = 3'd7;
    tick();
    s_idle();
    @(negedge clk);
    chk("s cnt after issue", 32'(s_pending_cnt), 1);
    s_iss_valid = 1; s_iss_use_a = 1; s_rd_a_addr = 3'd7;
    @(negedge clk);
    chk("s raw stall", 32'(s_iss_ready), 0);
    tick();
    s_wb_valid = 1; s_wb_addr = 3'd7; s_wb_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("s raw unstall", 32'(s_iss_ready), 1);
    chk("s raw bypass", s_rd_a_data, 32'hDEADBEEF);
    tick();
    s_idle(); s_rd_b_addr = 3'd7;
    @(negedge clk);
    chk("s raw cnt", 32'(s_pending_cnt), 0);
    chk("s raw regs", s_rd_b_data, 32'hDEADBEEF);
    chk("s wb_err", 32'(s_wb_err), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
